rv32_mem_arbiter: RTL

Two-master to one-slave memory arbiter directly downstream of the rv32 core. It merges the core's instruction-fetch port and data port onto a single req/gnt/rvalid memory port, so the core can run from one unified SRAM or bus. It tracks in-flight transactions by source ID in an in-order FIFO and steers each response back to the master that issued it.

---
 rtl/rv32_mem_arbiter.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/rv32_mem_arbiter.sv
// ---------------------------------------------------------------------------
// rv32_mem_arbiter
//
// Merges the rv32 core's instruction-fetch port and data port onto a single
// OBI-style req/gnt/rvalid memory port. Every accepted transaction records its
// source (INSTR or DATA) in an in-order FIFO. Each memory response is steered
// back to the master at the head of that FIFO. Both the request path and the
// response path are purely combinational, so the arbiter adds no cycles.
//
// Compile-time option:
//   RV32_ARB_RR_EN  defined   -> round-robin between the two masters on
//                                contention (the one that was not last_src
//                                wins)
//                   undefined -> fixed priority, data over instruction
//
// Parameters:
//   MAX_OUTSTANDING  accepted-but-unanswered transactions allowed (1..8)
//   ADDR_W           address width of all ports
//
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   instr_*              fetch master: addr/req in; gnt/rdata/rvalid out
//   data_*               load/store master: addr/wdata/req/we/be in;
//                        gnt/rdata/rvalid out
//   mem_*                memory slave: addr/wdata/req/we/be out;
//                        gnt/rdata/rvalid in
//   err_o                sticky protocol error, cleared only by reset
// ---------------------------------------------------------------------------
module rv32_mem_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int ADDR_W          = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic [ADDR_W-1:0] instr_addr_i,
    input  logic              instr_req_i,
    output logic              instr_gnt_o,
    output logic [31:0]       instr_rdata_o,
    output logic              instr_rvalid_o,

    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [31:0]       data_wdata_i,
    input  logic              data_req_i,
    input  logic              data_we_i,
    input  logic [3:0]        data_be_i,
    output logic              data_gnt_o,
    output logic [31:0]       data_rdata_o,
    output logic              data_rvalid_o,

    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    input  logic              mem_gnt_i,
    input  logic [31:0]       mem_rdata_i,
    input  logic              mem_rvalid_i,

    output logic              err_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

    typedef enum logic {
        SRC_INSTR = 1'b0,
        SRC_DATA  = 1'b1
    } src_e;

    typedef enum logic [1:0] {
        LOCK_NONE  = 2'd0,
        LOCK_INSTR = 2'd1,
        LOCK_DATA  = 2'd2
    } lock_e;

    lock_e             lock_q;
    lock_e             lock_d;
    src_e              last_src_q;
    logic              err_q;
    logic [CNT_W-1:0]  count_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    src_e              fifo_q [MAX_OUTSTANDING];

    src_e              sel;
    logic              sel_req;
    logic              fifo_full;
    logic              fifo_empty;
    logic              accept;
    logic              pop;
    logic              lock_err;
    src_e              head_src;

    // Wrap a FIFO pointer modulo MAX_OUTSTANDING, which need not be a power
    // of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign fifo_full  = (count_q == CNT_MAX);
    assign fifo_empty = (count_q == '0);

    // Source selection. A held lock pins the selection to the master that is
    // still waiting for its grant, so its address cannot be swapped out from
    // under the slave. Without a lock, a lone requester wins. On contention
    // the build option decides between fixed priority and round-robin.
    always_comb begin
        sel = SRC_INSTR;
        case (lock_q)
            LOCK_INSTR: sel = SRC_INSTR;
            LOCK_DATA:  sel = SRC_DATA;
            default: begin
                if (instr_req_i && data_req_i) begin
`ifdef RV32_ARB_RR_EN
                    sel = (last_src_q == SRC_DATA) ? SRC_INSTR : SRC_DATA;
`else
                    sel = SRC_DATA;
`endif
                end else if (data_req_i) begin
                    sel = SRC_DATA;
                end else begin
                    sel = SRC_INSTR;
                end
            end
        endcase
    end

`ifndef RV32_ARB_RR_EN
    // With fixed priority, last_src is only tracked, never consulted.
    logic unused_last_src;
    assign unused_last_src = last_src_q;
`endif

    // A full FIFO blocks issue for the whole cycle, even if a response pops
    // an entry in that same cycle. Reset masks the request immediately.
    assign sel_req   = (sel == SRC_DATA) ? data_req_i : instr_req_i;
    assign mem_req_o = sel_req & ~fifo_full & ~rst_i;
    assign accept    = mem_req_o & mem_gnt_i;

    assign instr_gnt_o = accept & (sel == SRC_INSTR);
    assign data_gnt_o  = accept & (sel == SRC_DATA);

    // Request mux. Fetches are always full-word reads, so the instruction
    // side supplies constant we/be/wdata.
    always_comb begin
        mem_addr_o  = instr_addr_i;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'hF;
        mem_wdata_o = '0;
        if (sel == SRC_DATA) begin
            mem_addr_o  = data_addr_i;
            mem_we_o    = data_we_i & ~rst_i;
            mem_be_o    = data_be_i;
            mem_wdata_o = data_wdata_i;
        end
    end

    // Response steering. A response with nothing outstanding goes to no one
    // (it only raises err_o). The master that is not at the head sees zeros.
    assign head_src = fifo_q[rd_ptr_q];
    assign pop      = mem_rvalid_i & ~fifo_empty;

    assign instr_rvalid_o = pop & (head_src == SRC_INSTR);
    assign data_rvalid_o  = pop & (head_src == SRC_DATA);
    assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
    assign data_rdata_o   = data_rvalid_o  ? mem_rdata_i : '0;

    // Lock next-state. A lock is taken when the selected request is presented
    // but not granted. It is released on acceptance. It is also released when
    // the locked master withdraws its request; that is a protocol violation
    // and is flagged.
    always_comb begin
        lock_d   = lock_q;
        lock_err = 1'b0;
        case (lock_q)
            LOCK_INSTR, LOCK_DATA: begin
                if (!sel_req) begin
                    lock_d   = LOCK_NONE;
                    lock_err = 1'b1;
                end else if (accept) begin
                    lock_d = LOCK_NONE;
                end
            end
            default: begin
                if (mem_req_o && !mem_gnt_i) begin
                    lock_d = (sel == SRC_DATA) ? LOCK_DATA : LOCK_INSTR;
                end
            end
        endcase
    end

    // Lock state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_q <= LOCK_NONE;
        end else begin
            lock_q <= lock_d;
        end
    end

    // Outstanding-transaction FIFO: push the source ID on acceptance and pop
    // the head on every response. A simultaneous push and pop leaves the count
    // unchanged.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_q[i] <= SRC_INSTR;
            end
        end else begin
            if (accept) begin
                fifo_q[wr_ptr_q] <= sel;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({accept, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // The last accepted source feeds round-robin arbitration. The sticky error
    // collects responses with nothing outstanding and withdrawn locked
    // requests.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_src_q <= SRC_INSTR;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                last_src_q <= sel;
            end
            if (lock_err || (mem_rvalid_i && fifo_empty)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_o = err_q;

endmodule
